uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single UART transmitter between NUM_REQ byte requesters.
- Sits in uart_top between client logic and the tx_fsm tx_start / tx_data_in / tx_busy interface.
- Holds tx_start until the transmitter accepts the byte on its next bit tick, then waits for the frame to finish.
- A watchdog drops a byte that is never accepted.

Parameters:
ID_W, 2, requester index width; NUM_REQ = 2**ID_W (localparam).
TIMEOUT_CYCLES, 1024, maximum clk_50mhz cycles in LAUNCH waiting for tx_busy to rise; must be > tx_divider+2; range 2..65535.

Ports:
clk_50mhz  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  requester i has a byte pending; held until its req_ready pulse.
req_data  input  8*NUM_REQ  byte of requester i on [8i+7:8i]; stable while req_valid[i]=1.
req_ready  output  NUM_REQ  one-cycle acknowledge: the byte of requester i was captured.
tx_start  output  1  to tx_fsm tx_start.
tx_data  output  8  to tx_fsm tx_data_in; captured byte.
tx_busy  input  1  from tx_fsm tx_busy.
grant_id  output  ID_W  index of the requester whose byte is in flight.
active  output  1  1 in LAUNCH or WAIT_DONE.
timeout_err  output  1  one-cycle pulse when a byte is dropped by the watchdog.
sent_count  output  16  frames completed; wraps 65535->0.

Behaviour:
- Reset values (async, all registered outputs): req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, timeout_err=0, sent_count=0.
- Reset state: state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), wd_cnt=0.
- State machine: IDLE, LAUNCH, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and req_valid!=0, select winner w = first set bit scanning last_grant+1, +2, ... mod NUM_REQ.
  - At that edge: tx_data<=req_data[w], grant_id<=w, last_grant<=w, req_ready[w]<=1 (one cycle only), tx_start<=1, active<=1, wd_cnt<=0, state<=LAUNCH.
  - If tx_busy=1, no grant, regardless of req_valid.
  - Latency: req_valid seen at edge N gives req_ready and tx_start high in cycle N+1.
- LAUNCH:
  - tx_start held 1; wd_cnt increments each cycle.
  - If tx_busy=1: tx_start<=0, state<=WAIT_DONE.
  - Else if wd_cnt==TIMEOUT_CYCLES-1: tx_start<=0, active<=0, timeout_err<=1 (one cycle), state<=IDLE. Byte is dropped; last_grant stays w.
  - If both conditions hold in the same cycle, tx_busy wins (no error).
- WAIT_DONE:
  - When tx_busy=0: sent_count<=sent_count+1, active<=0, state<=IDLE.
  - Earliest next grant is the cycle after the return to IDLE.
- req_valid and req_data are sampled only in IDLE. A requester that deasserts req_valid before being granted is simply skipped. Holding req_valid after req_ready is presenting the next byte.
- Exactly one req_ready bit is high at a time; never in a cycle without a grant.
- tx_data and grant_id hold their last value after completion or timeout.
- Reset mid-operation (any state): immediate return to reset values; a byte in flight is lost with no report, and sent_count clears.
- Unknown state encoding: go to IDLE.

Test Plan:
1. Single request: req_valid[0]=1, req_data[7:0]=8'hA5, tx_fsm with tx_divider=434 -> req_ready[0] pulses 1 cycle, tx_start high until tx_busy rises (<=436 cycles), tx_line frames 0xA5 LSB-first, active falls with tx_busy, sent_count=1.
2. All four requests valid together, data 8'h10/8'h21/8'h32/8'h43 -> grant order 0,1,2,3; tx_data in that order; four single req_ready pulses; sent_count=4; no overlapping tx_start.
3. Fairness: req_valid[0] and req_valid[2] held high continuously -> grant_id sequence 0,2,0,2,...; requesters 1 and 3 are never granted.
4. Watchdog: TIMEOUT_CYCLES=16, tx_busy tied 0, req_valid=4'b0011 -> timeout_err pulses in the 16th cycle after tx_start rises, tx_start drops, sent_count stays 0, next grant_id=1.
5. Busy blocking: tx_busy=1 at reset release with req_valid[3]=1 -> no req_ready and no tx_start until tx_busy falls; grant follows 1 cycle later.
6. Reset mid-frame: assert rst_n=0 during WAIT_DONE -> all outputs return to reset values asynchronously. After release, a request on req_valid[1] only is granted as grant_id=1; a later simultaneous request from requesters 0 and 1 grants 0 first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding client logic and tx_fsm.
interface uart_tx_arbiter_if #(
  parameter int ID_W = 2
);
  localparam int NUM_REQ = 1 << ID_W;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data
  );

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte requesters.
// A granted byte is captured, and tx_start is held until tx_fsm raises
// tx_busy. The arbiter then waits for the frame to end. A watchdog drops a
// byte that the transmitter never accepts.
module uart_tx_arbiter #(
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_50mhz,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus,
  output logic [ID_W-1:0]   grant_id,
  output logic              active,
  output logic              timeout_err,
  output logic [15:0]       sent_count
);

  localparam int NUM_REQ = 1 << ID_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  // Last wd_cnt value still allowed in LAUNCH before the byte is dropped
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state;
  logic [ID_W-1:0]    last_grant;
  logic [15:0]        wd_cnt;
  logic [NUM_REQ-1:0] req_ready_r;
  logic               tx_start_r;
  logic [7:0]         tx_data_r;

  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic [7:0]         win_data;

  assign bus.req_ready = req_ready_r;
  assign bus.tx_start  = tx_start_r;
  assign bus.tx_data   = tx_data_r;

  // Round-robin winner: first pending requester after last_grant, wrapping
  // modulo NUM_REQ. The last candidate examined is last_grant itself.
  always_comb begin
    win_id    = last_grant;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && bus.req_valid[last_grant + ID_W'(k)]) begin
        win_id    = last_grant + ID_W'(k);
        win_found = 1'b1;
      end
    end
    win_data = bus.req_data[{win_id, 3'b000} +: 8];
  end

  // Grant / launch / wait-for-frame sequencer with launch watchdog
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      wd_cnt      <= 16'd0;
      req_ready_r <= '0;
      tx_start_r  <= 1'b0;
      tx_data_r   <= 8'd0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
      sent_count  <= 16'd0;
    end else begin
      req_ready_r <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.tx_busy && win_found) begin
            tx_data_r   <= win_data;
            grant_id    <= win_id;
            last_grant  <= win_id;
            req_ready_r <= NUM_REQ'(1) << win_id;
            tx_start_r  <= 1'b1;
            active      <= 1'b1;
            wd_cnt      <= 16'd0;
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wd_cnt <= wd_cnt + 16'd1;
          // Acceptance wins over a simultaneous watchdog expiry
          if (bus.tx_busy) begin
            tx_start_r <= 1'b0;
            state      <= ST_WAIT_DONE;
          end else if (wd_cnt == WD_LAST) begin
            tx_start_r  <= 1'b0;
            active      <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            sent_count <= sent_count + 16'd1;
            active     <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          tx_start_r <= 1'b0;
          active     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
